core_y_drive_sequencer: RTL
===========================

# core_y_drive_sequencer

Downstream consumer of the sector-register Y-address decode. Takes the active-low one-hot Y-select lines (AY00N..AY70N, as an 8-bit bus) and sequences one destructive-read / restore core-memory cycle: drives the selected Y read line, strobes the sense amplifiers, latches the read word, then drives the Y write line with per-bit inhibits to restore the old word or write new data. Sits between the sector/address decode and the core-plane driver/sense interface.

## Interface
- READ_CYCLES, default 4: clocks Y read drive is held (≥2).
- WRITE_CYCLES, default 4: clocks Y write drive/inhibit is held (≥1).
- WIDTH, default 28: memory word width (two 13-bit syllables plus two parity bits).
- CLK  in  1  single system clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  cycle request; sampled only in IDLE.
- WRITE  in  1  sampled with START: 1 = store WDATA, 0 = read and restore.
- AY_N  in  8  active-low one-hot Y select from the sector decode; sampled with START.
- WDATA  in  WIDTH  store data; sampled with START.
- SENSE_IN  in  WIDTH  sense-amplifier outputs; sampled at the sense strobe.
- YRD  out  8  active-high one-hot Y read drive.
- YWR  out  8  active-high one-hot Y write drive.
- INH  out  WIDTH  per-bit inhibit; high suppresses writing a 1.
- SENSE_STB  out  1  sense-amplifier strobe.
- RDATA  out  WIDTH  word latched at sense strobe.
- BUSY  out  1  cycle in progress.
- DONE  out  1  one-clock completion pulse.
- ERR  out  1  one-clock pulse: AY_N not one-hot at START.

## Operation
- States: IDLE, READ, GAP, RESTORE. Internal down-counter sized for max(READ_CYCLES, WRITE_CYCLES).
- IDLE + START: decode sel = ~AY_N. If sel has exactly one bit set: latch sel, WRITE, WDATA; go READ, counter = READ_CYCLES-1. Otherwise (zero or ≥2 lines low): ERR pulse next cycle, stay IDLE, no drive asserted.
- READ: YRD = sel. In the final READ cycle (counter = 0) SENSE_STB = 1 and RDATA captures SENSE_IN on that cycle's closing edge. Next: GAP.
- GAP: exactly one cycle, all drives and INH low. Restore word = WDATA latch if WRITE, else RDATA. Next: RESTORE, counter = WRITE_CYCLES-1.
- RESTORE: YWR = sel, INH = ~restore word. At counter = 0 go IDLE with DONE pulse.
- START outside IDLE ignored (no queue). START in the DONE cycle (already IDLE) is accepted.
- RDATA holds its value until the next sense strobe; on a write cycle RDATA still captures the sensed (old) word.
- YRD and YWR never asserted in the same cycle; INH is zero whenever YWR is zero.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Reset values: YRD=0, YWR=0, INH=0, SENSE_STB=0, RDATA=0, BUSY=0, DONE=0, ERR=0, state IDLE.
- With START sampled at edge 0 (R=READ_CYCLES, W=WRITE_CYCLES): YRD high cycles 1..R; SENSE_STB cycle R; RDATA valid from R+1; GAP cycle R+1; YWR/INH cycles R+2..R+1+W; DONE and BUSY=0 in cycle R+2+W.
- BUSY high cycles 1..R+1+W. Total latency START to DONE = R+W+2 clocks.
- ERR: cycle 1 after an invalid START; BUSY stays 0.
- RESET mid-cycle: all drives drop immediately (asynchronously); latched cycle discarded; no DONE.

## Structure
- Shared package: state enum (IDLE, READ, GAP, RESTORE), sector count constant 8, default WIDTH 28.
- One sub-module: onehot8_check (8-bit one-hot validity, combinational), reusable for the DS/IS sector lines.

## Test plan
- Read: R=W=4, AY_N=8'hFB, WRITE=0, SENSE_IN=28'h5A5A5A5 -> YRD=8'h04 cycles 1–4, SENSE_STB cycle 4, GAP cycle 5, YWR=8'h04 with INH=28'hA5A5A5A cycles 6–9, DONE cycle 10, RDATA=28'h5A5A5A5.
- Write: AY_N=8'h7F, WDATA=28'h0000001, SENSE_IN=28'hFFFFFFF -> YRD/YWR=8'h80, INH=28'hFFFFFFE, RDATA=28'hFFFFFFF.
- Invalid select: AY_N=8'hFF then 8'hF3 -> ERR cycle 1, YRD/YWR/BUSY stay 0.
- START held high throughout -> ignored while BUSY; second cycle begins one edge after DONE cycle (back-to-back, BUSY low for exactly the DONE cycle).
- RESET asserted in cycle 7 of a cycle -> YWR, INH, BUSY zero asynchronously; no DONE; next START runs a normal cycle.
- Sweep all 8 one-hot AY_N values, R=2 W=1 -> drive matches sel, latency 5.

Source files
------------

// File: rtl/core_y_drive_sequencer_pkg.sv
// Shared definitions for the core Y drive sequencer and its sector-line helpers.
//   - seq_state_t   : sequencer state encoding (IDLE, READ, GAP, RESTORE)
//   - SECTOR_COUNT  : number of one-hot Y/sector select lines
//   - DEFAULT_WIDTH : core word width (two 13-bit syllables + two parity bits)
//   - cnt_width()   : width of a down-counter that can hold max(a, b) - 1
package core_y_drive_sequencer_pkg;

    localparam int SECTOR_COUNT  = 8;
    localparam int DEFAULT_WIDTH = 28;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_GAP     = 2'd2,
        ST_RESTORE = 2'd3
    } seq_state_t;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/core_y_drive_sequencer_onehot8_check.sv
// onehot8_check: combinational one-hot validity test for an 8-line select bus.
// Shared with the DS/IS sector lines, so it knows nothing about polarity:
// callers invert active-low buses before presenting them.
//   sel   in  8  active-high select lines
//   valid out 1  exactly one line of sel is set
module onehot8_check
    import core_y_drive_sequencer_pkg::*;
(
    input  logic [SECTOR_COUNT-1:0] sel,
    output logic                    valid
);

    localparam logic [SECTOR_COUNT-1:0] ONE = SECTOR_COUNT'(1);

    // x & (x-1) clears the lowest set bit; zero result means at most one bit.
    assign valid = (sel != '0) && ((sel & (sel - ONE)) == '0);

endmodule

// File: rtl/core_y_drive_sequencer.sv
// core_y_drive_sequencer: sequences one destructive-read / restore core cycle
// for the Y line selected by the active-low one-hot sector decode.
//   CLK, RESET      clock; asynchronous active-high reset
//   START           cycle request, sampled only in IDLE
//   WRITE           with START: 1 = store WDATA, 0 = read and restore
//   AY_N [8]        active-low one-hot Y select, sampled with START
//   WDATA [WIDTH]   store data, sampled with START
//   SENSE_IN [WIDTH] sense-amplifier outputs, captured at the sense strobe
//   YRD / YWR [8]   active-high one-hot Y read / write drive
//   INH [WIDTH]     per-bit inhibit during write drive (high blocks a 1)
//   SENSE_STB       sense strobe, last READ cycle
//   RDATA [WIDTH]   word captured at the sense strobe
//   BUSY, DONE, ERR cycle in progress, completion pulse, bad-select pulse
// Every output is a flop loaded from the next-state decode, so nothing on an
// input reaches an output without passing a clock edge.
module core_y_drive_sequencer
    import core_y_drive_sequencer_pkg::*;
#(
    parameter int READ_CYCLES  = 4,
    parameter int WRITE_CYCLES = 4,
    parameter int WIDTH        = DEFAULT_WIDTH
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    START,
    input  logic                    WRITE,
    input  logic [SECTOR_COUNT-1:0] AY_N,
    input  logic [WIDTH-1:0]        WDATA,
    input  logic [WIDTH-1:0]        SENSE_IN,
    output logic [SECTOR_COUNT-1:0] YRD,
    output logic [SECTOR_COUNT-1:0] YWR,
    output logic [WIDTH-1:0]        INH,
    output logic                    SENSE_STB,
    output logic [WIDTH-1:0]        RDATA,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    ERR
);

    localparam int            CW      = cnt_width(READ_CYCLES, WRITE_CYCLES);
    localparam logic [CW-1:0] RD_LOAD = CW'(READ_CYCLES - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    seq_state_t              state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [SECTOR_COUNT-1:0] sel_q, sel_nxt;
    logic [SECTOR_COUNT-1:0] sel_dec;
    logic                    sel_ok;
    logic                    wr_q;
    logic [WIDTH-1:0]        wdata_q;
    logic [WIDTH-1:0]        restore_word;
    logic                    accept, reject, done_nxt;

    assign sel_dec = ~AY_N;

    onehot8_check u_ay_check (
        .sel   (sel_dec),
        .valid (sel_ok)
    );

    // RDATA is already loaded when GAP hands over to RESTORE, so a read
    // cycle restores exactly the word the strobe captured.
    assign restore_word = wr_q ? wdata_q : RDATA;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel_q;
        accept    = 1'b0;
        reject    = 1'b0;
        done_nxt  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (START) begin
                    if (sel_ok) begin
                        accept    = 1'b1;
                        sel_nxt   = sel_dec;
                        state_nxt = ST_READ;
                        cnt_nxt   = RD_LOAD;
                    end else begin
                        reject    = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (cnt == '0) state_nxt = ST_GAP;
                else           cnt_nxt   = cnt - CNT_ONE;
            end
            ST_GAP: begin
                state_nxt = ST_RESTORE;
                cnt_nxt   = WR_LOAD;
            end
            ST_RESTORE: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = cnt - CNT_ONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            sel_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sel_q <= sel_nxt;
            if (accept) begin
                wr_q    <= WRITE;
                wdata_q <= WDATA;
            end
        end
    end

    // Output flops: decoded from the state being entered, so each output
    // lines up with the cycle its state occupies.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            YRD       <= '0;
            YWR       <= '0;
            INH       <= '0;
            SENSE_STB <= 1'b0;
            RDATA     <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            YRD       <= (state_nxt == ST_READ)    ? sel_nxt       : '0;
            YWR       <= (state_nxt == ST_RESTORE) ? sel_nxt       : '0;
            INH       <= (state_nxt == ST_RESTORE) ? ~restore_word : '0;
            SENSE_STB <= (state_nxt == ST_READ) && (cnt_nxt == '0);
            BUSY      <= (state_nxt != ST_IDLE);
            DONE      <= done_nxt;
            ERR       <= reject;
            // Capture on the edge that closes the strobe cycle; held until
            // the next strobe, including across write cycles.
            if (SENSE_STB) RDATA <= SENSE_IN;
        end
    end

endmodule
